// File: rtl/pong_vga_top.sv
// pong_vga_top: single-player Pong on a 640x480 VGA display.
// The block has a left-edge paddle driven by the up and down buttons, and a bouncing ball.
// It also contains the VGA timing generator, the per-frame game update and a registered pixel renderer.
// Optional build macro PONG_BORDER_EN draws an 8-pixel blue border on the top, bottom and right edges.
// The collision limits do not depend on this macro.
module pong_vga_top #(
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_SIZE   = 8,
  parameter int BALL_SPEED  = 2
) (
  input  logic ClkPort,
  input  logic Sw0,
  input  logic Sw1,
  input  logic btnU,
  input  logic btnD,
  output logic St_ce_bar,
  output logic St_rp_bar,
  output logic Mt_ce_bar,
  output logic Mt_St_oe_bar,
  output logic Mt_St_we_bar,
  output logic vga_h_sync,
  output logic vga_v_sync,
  output logic vga_r,
  output logic vga_g,
  output logic vga_b
);

  // 640x480 timing, counted in pixels and lines
  localparam int H_TOTAL  = 800;
  localparam int H_VIS    = 640;
  localparam int HS_FIRST = 656;
  localparam int HS_LAST  = 751;
  localparam int V_TOTAL  = 525;
  localparam int V_VIS    = 480;
  localparam int VS_FIRST = 490;
  localparam int VS_LAST  = 491;

  // playfield geometry
  localparam int PADDLE_X_LEFT  = 16;
  localparam int PADDLE_X_END   = 24;
  localparam int PADDLE_Y_MAX   = V_VIS - PADDLE_H;
  localparam int PADDLE_Y_RESET = PADDLE_Y_MAX / 2;
  localparam int BALL_X_MAX     = H_VIS - BALL_SIZE;
  localparam int BALL_Y_MAX     = V_VIS - BALL_SIZE;
  localparam int BALL_X_RESET   = BALL_X_MAX / 2;
  localparam int BALL_Y_RESET   = BALL_Y_MAX / 2;
`ifdef PONG_BORDER_EN
  localparam int BORDER_W       = 8;
`endif

  localparam logic signed [11:0] SPEED_S      = 12'(BALL_SPEED);
  localparam logic signed [11:0] ZERO_S       = 12'sd0;
  localparam logic signed [11:0] BALL_X_MAX_S = 12'(BALL_X_MAX);
  localparam logic signed [11:0] BALL_Y_MAX_S = 12'(BALL_Y_MAX);
  localparam logic signed [11:0] HIT_X_S      = 12'(PADDLE_X_END);

  logic       reset;
  logic       pe;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       frame_tick;

  logic [2:0] in_meta;
  logic [2:0] in_sync;
  logic       up_held;
  logic       down_held;
  logic       paused;

  logic [9:0] paddle_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       ball_dx_neg;
  logic       ball_dy_neg;

  logic [9:0] paddle_y_nxt;
  logic [9:0] ball_x_nxt;
  logic [9:0] ball_y_nxt;
  logic       ball_dx_neg_nxt;
  logic       ball_dy_neg_nxt;

  logic signed [11:0] bx_s;
  logic signed [11:0] by_s;
  logic signed [11:0] next_bx;
  logic signed [11:0] next_by;
  logic [10:0] ball_bottom;
  logic [10:0] paddle_bottom;
  logic        overlap;

  logic       h_visible;
  logic       v_visible;
  logic       ball_px;
  logic       paddle_px;
  logic       border_px;
  logic       h_sync_nxt;
  logic       v_sync_nxt;
  logic [2:0] rgb_nxt;

  // The flash and RAM chips share buses with other parts, so their selects stay inactive.
  assign St_ce_bar    = 1'b1;
  assign St_rp_bar    = 1'b1;
  assign Mt_ce_bar    = 1'b1;
  assign Mt_St_oe_bar = 1'b1;
  assign Mt_St_we_bar = 1'b1;

  assign reset = Sw0;

  // The pixel enable runs at half the system clock, so the pixel clock is ClkPort/2.
  always_ff @(posedge ClkPort) begin
    if (reset) pe <= 1'b0;
    else       pe <= ~pe;
  end

  // The horizontal and vertical raster counters advance once per pixel.
  always_ff @(posedge ClkPort) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pe) begin
      if (hcnt == 10'(H_TOTAL - 1)) begin
        hcnt <= '0;
        if (vcnt == 10'(V_TOTAL - 1)) vcnt <= '0;
        else                          vcnt <= vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  assign frame_tick = pe && (hcnt == 10'd0) && (vcnt == 10'(V_VIS));

  // Two-flop synchronisers for the asynchronous buttons and the pause switch.
  always_ff @(posedge ClkPort) begin
    if (reset) begin
      in_meta <= '0;
      in_sync <= '0;
    end else begin
      in_meta <= {Sw1, btnD, btnU};
      in_sync <= in_meta;
    end
  end

  assign up_held   = in_sync[0];
  assign down_held = in_sync[1];
  assign paused    = in_sync[2];

  assign bx_s    = $signed({2'b00, ball_x});
  assign by_s    = $signed({2'b00, ball_y});
  assign next_bx = ball_dx_neg ? (bx_s - SPEED_S) : (bx_s + SPEED_S);
  assign next_by = ball_dy_neg ? (by_s - SPEED_S) : (by_s + SPEED_S);

  assign ball_bottom   = {1'b0, ball_y} + 11'(BALL_SIZE - 1);
  assign paddle_bottom = {1'b0, paddle_y} + 11'(PADDLE_H - 1);
  assign overlap       = (ball_bottom >= {1'b0, paddle_y}) && ({1'b0, ball_y} <= paddle_bottom);

  // Compute the game state for the next frame.
  // The x and y rules are independent, and a miss overrides both of them.
  always_comb begin
    paddle_y_nxt    = paddle_y;
    ball_x_nxt      = ball_x;
    ball_y_nxt      = ball_y;
    ball_dx_neg_nxt = ball_dx_neg;
    ball_dy_neg_nxt = ball_dy_neg;

    if (up_held && !down_held) begin
      if (paddle_y < 10'(PADDLE_STEP)) paddle_y_nxt = '0;
      else                             paddle_y_nxt = paddle_y - 10'(PADDLE_STEP);
    end else if (down_held && !up_held) begin
      if (paddle_y > 10'(PADDLE_Y_MAX - PADDLE_STEP)) paddle_y_nxt = 10'(PADDLE_Y_MAX);
      else                                             paddle_y_nxt = paddle_y + 10'(PADDLE_STEP);
    end

    if (next_by <= ZERO_S) begin
      ball_y_nxt      = '0;
      ball_dy_neg_nxt = 1'b0;
    end else if (next_by >= BALL_Y_MAX_S) begin
      ball_y_nxt      = 10'(BALL_Y_MAX);
      ball_dy_neg_nxt = 1'b1;
    end else begin
      ball_y_nxt      = next_by[9:0];
    end

    if (next_bx >= BALL_X_MAX_S) begin
      ball_x_nxt      = 10'(BALL_X_MAX);
      ball_dx_neg_nxt = 1'b1;
    end else if (ball_dx_neg && (next_bx <= HIT_X_S) && overlap) begin
      ball_x_nxt      = 10'(PADDLE_X_END);
      ball_dx_neg_nxt = 1'b0;
    end else begin
      ball_x_nxt      = next_bx[9:0];
    end

    if (ball_dx_neg && (next_bx <= ZERO_S) && !overlap) begin
      ball_x_nxt      = 10'(BALL_X_RESET);
      ball_y_nxt      = 10'(BALL_Y_RESET);
      ball_dx_neg_nxt = 1'b0;
      ball_dy_neg_nxt = 1'b0;
    end
  end

  // Commit the game state once per frame, during vertical blanking, unless the game is paused.
  always_ff @(posedge ClkPort) begin
    if (reset) begin
      paddle_y    <= 10'(PADDLE_Y_RESET);
      ball_x      <= 10'(BALL_X_RESET);
      ball_y      <= 10'(BALL_Y_RESET);
      ball_dx_neg <= 1'b0;
      ball_dy_neg <= 1'b0;
    end else if (frame_tick && !paused) begin
      paddle_y    <= paddle_y_nxt;
      ball_x      <= ball_x_nxt;
      ball_y      <= ball_y_nxt;
      ball_dx_neg <= ball_dx_neg_nxt;
      ball_dy_neg <= ball_dy_neg_nxt;
    end
  end

  assign h_visible = hcnt < 10'(H_VIS);
  assign v_visible = vcnt < 10'(V_VIS);

  assign ball_px = ({1'b0, hcnt} >= {1'b0, ball_x}) &&
                   ({1'b0, hcnt} <  ({1'b0, ball_x} + 11'(BALL_SIZE))) &&
                   ({1'b0, vcnt} >= {1'b0, ball_y}) &&
                   ({1'b0, vcnt} <  ({1'b0, ball_y} + 11'(BALL_SIZE)));

  assign paddle_px = (hcnt >= 10'(PADDLE_X_LEFT)) && (hcnt < 10'(PADDLE_X_END)) &&
                     ({1'b0, vcnt} >= {1'b0, paddle_y}) &&
                     ({1'b0, vcnt} <  ({1'b0, paddle_y} + 11'(PADDLE_H)));

`ifdef PONG_BORDER_EN
  assign border_px = (vcnt < 10'(BORDER_W)) ||
                     (vcnt >= 10'(V_VIS - BORDER_W)) ||
                     (hcnt >= 10'(H_VIS - BORDER_W));
`else
  assign border_px = 1'b0;
`endif

  // Pick the colour and sync levels for the current pixel.
  // The ball has priority over the paddle, and the paddle over the border.
  always_comb begin
    rgb_nxt    = 3'b000;
    h_sync_nxt = !((hcnt >= 10'(HS_FIRST)) && (hcnt <= 10'(HS_LAST)));
    v_sync_nxt = !((vcnt >= 10'(VS_FIRST)) && (vcnt <= 10'(VS_LAST)));
    if (h_visible && v_visible) begin
      if (ball_px)        rgb_nxt = 3'b100;
      else if (paddle_px) rgb_nxt = 3'b010;
      else if (border_px) rgb_nxt = 3'b001;
    end
  end

  // Register every video output so that the pins change cleanly once per pixel.
  always_ff @(posedge ClkPort) begin
    if (reset) begin
      vga_h_sync <= 1'b1;
      vga_v_sync <= 1'b1;
      vga_r      <= 1'b0;
      vga_g      <= 1'b0;
      vga_b      <= 1'b0;
    end else if (pe) begin
      vga_h_sync <= h_sync_nxt;
      vga_v_sync <= v_sync_nxt;
      vga_r      <= rgb_nxt[2];
      vga_g      <= rgb_nxt[1];
      vga_b      <= rgb_nxt[0];
    end
  end

endmodule

// File: tb/tb_pong_vga_top.sv
// Self-checking bench for pong_vga_top.
// A reference model of the raster and the game pushes the expected pixels and positions into a queue.
// The entries are popped and compared just after each clock edge.
// The raster counters are jumped ahead so that the bench can reach frame ticks and screen regions quickly.
module tb_pong_vga_top;

  logic ClkPort;
  logic Sw0, Sw1, btnU, btnD;
  logic St_ce_bar, St_rp_bar, Mt_ce_bar, Mt_St_oe_bar, Mt_St_we_bar;
  logic vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b;

  pong_vga_top dut (
    .ClkPort(ClkPort), .Sw0(Sw0), .Sw1(Sw1), .btnU(btnU), .btnD(btnD),
    .St_ce_bar(St_ce_bar), .St_rp_bar(St_rp_bar), .Mt_ce_bar(Mt_ce_bar),
    .Mt_St_oe_bar(Mt_St_oe_bar), .Mt_St_we_bar(Mt_St_we_bar),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  initial ClkPort = 1'b0;
  always #10 ClkPort = ~ClkPort;

  typedef struct {
    int          kind;
    int          h;
    int          v;
    logic [31:0] val;
  } exp_t;

  exp_t expQ[$];
  exp_t e;
  int   nChecks = 0;
  int   nPass   = 0;

  // reference model state
  bit mpe;
  bit frameEdge;
  int mh, mv;
  int mpy, mbx, mby, mdx, mdy;
  int hits = 0;
  int misses = 0;

  // raster jump requests from the stimulus process
  int jumpSeq = 0;
  int seenSeq = 0;
  int jumpH = 0;
  int jumpV = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed === expected) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
  endtask

  task automatic resetGame();
    mpy = 208; mbx = 316; mby = 236; mdx = 2; mdy = 2;
  endtask

  // Expected output word {hsync, vsync, r, g, b} for the pixel at (h, v).
  function automatic logic [4:0] pixelExp(input int h, input int v);
    logic hs, vs;
    logic [2:0] rgb;
    hs  = !(h >= 656 && h <= 751);
    vs  = !(v == 490 || v == 491);
    rgb = 3'b000;
    if (h < 640 && v < 480) begin
      if (h >= mbx && h < mbx + 8 && v >= mby && v < mby + 8) rgb = 3'b100;
      else if (h >= 16 && h <= 23 && v >= mpy && v <= mpy + 63) rgb = 3'b010;
`ifdef PONG_BORDER_EN
      else if (v < 8 || v >= 472 || h >= 632) rgb = 3'b001;
`endif
    end
    return {hs, vs, rgb};
  endfunction

  // One frame of game rules, using the paddle and ball positions from before the update.
  task automatic updateGame();
    int nx, ny;
    bit ov;
    ov = (mby + 7 >= mpy) && (mby <= mpy + 63);
    nx = mbx + mdx;
    ny = mby + mdy;
    if (mdx < 0 && nx <= 0 && !ov) begin
      mbx = 316; mby = 236; mdx = 2; mdy = 2;
      misses++;
    end else begin
      if (ny <= 0)        begin mby = 0;   mdy = 2;  end
      else if (ny >= 472) begin mby = 472; mdy = -2; end
      else                      mby = ny;
      if (nx >= 632) begin mbx = 632; mdx = -2; end
      else if (mdx < 0 && nx <= 24 && ov) begin mbx = 24; mdx = 2; hits++; end
      else mbx = nx;
    end
    if (btnU && !btnD)      mpy = (mpy - 4 < 0)   ? 0   : mpy - 4;
    else if (btnD && !btnU) mpy = (mpy + 4 > 416) ? 416 : mpy + 4;
  endtask

  // The model steps on every clock edge and queues expectations.
  // The queue is drained and compared 1 ns after the edge.
  always @(posedge ClkPort) begin
    if (Sw0) begin
      mpe = 1'b0; mh = 0; mv = 0;
      resetGame();
      expQ.push_back('{0, 0, 0, 32'h18});
      expQ.push_back('{1, 0, 0, 32'd316});
      expQ.push_back('{2, 0, 0, 32'd236});
      expQ.push_back('{3, 0, 0, 32'd208});
      expQ.push_back('{4, 0, 0, 32'd0});
      expQ.push_back('{5, 0, 0, 32'd0});
      expQ.push_back('{6, 0, 0, 32'h1f});
    end else begin
      if (jumpSeq != seenSeq) begin
        mh = jumpH; mv = jumpV; seenSeq = jumpSeq;
      end
      if (mpe) expQ.push_back('{0, mh, mv, 32'(pixelExp(mh, mv))});
      frameEdge = mpe && mh == 0 && mv == 480;
      if (frameEdge && !Sw1) updateGame();
      if (frameEdge) begin
        expQ.push_back('{1, 0, 0, 32'(mbx)});
        expQ.push_back('{2, 0, 0, 32'(mby)});
        expQ.push_back('{3, 0, 0, 32'(mpy)});
      end
      if (mpe) begin
        if (mh == 799) begin
          mh = 0;
          mv = (mv == 524) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
      mpe = !mpe;
    end
    #1;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      case (e.kind)
        0: checkOutput($sformatf("pix(%0d,%0d)", e.h, e.v),
                       {27'd0, vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b}, e.val);
        1: checkOutput("ball_x", 32'(dut.ball_x), e.val);
        2: checkOutput("ball_y", 32'(dut.ball_y), e.val);
        3: checkOutput("paddle_y", 32'(dut.paddle_y), e.val);
        4: checkOutput("hcnt", 32'(dut.hcnt), e.val);
        5: checkOutput("vcnt", 32'(dut.vcnt), e.val);
        default: checkOutput("mem_ctl",
                       {27'd0, St_ce_bar, St_rp_bar, Mt_ce_bar, Mt_St_oe_bar, Mt_St_we_bar}, e.val);
      endcase
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge ClkPort);
  endtask

  // Move the DUT raster to (h, v) and tell the model to follow.
  task automatic jumpTo(input int h, input int v);
    @(negedge ClkPort);
    jumpH = h;
    jumpV = v;
    force dut.hcnt = jumpH[9:0];
    force dut.vcnt = jumpV[9:0];
    release dut.hcnt;
    release dut.vcnt;
    jumpSeq++;
  endtask

  task automatic applyStimulus(input logic up, input logic down, input logic pause);
    @(negedge ClkPort);
    btnU = up;
    btnD = down;
    Sw1  = pause;
    waitCycles(3);
  endtask

  // Skip to the end of the visible area so that one frame tick happens shortly afterwards.
  task automatic doTick();
    waitCycles(3);
    jumpTo(799, 479);
    waitCycles(8);
  endtask

  initial begin
    Sw0 = 1'b1; Sw1 = 1'b0; btnU = 1'b0; btnD = 1'b0;
    waitCycles(2);
    Sw0 = 1'b0;

    // first line: hsync window and blank or border pixels
    waitCycles(1700);

    // first frame renders the ball and the paddle at their reset positions
    jumpTo(300, 236); waitCycles(60);
    jumpTo(0, 210);   waitCycles(60);
    jumpTo(0, 271);   waitCycles(60);
    jumpTo(0, 272);   waitCycles(60);
    jumpTo(620, 479); waitCycles(60);
    jumpTo(790, 489); waitCycles(60);

    // one idle tick moves the ball to (318,238)
    doTick();

    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) doTick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 110; i++) doTick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) doTick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) doTick();
    jumpTo(0, mpy + 60); waitCycles(60);

    // reset in the middle of a frame
    jumpTo(400, 300); waitCycles(10);
    Sw0 = 1'b1; waitCycles(2);
    Sw0 = 1'b0; waitCycles(40);

    // track the ball with the paddle so that it bounces off the walls and the paddle
    for (int i = 0; i < 700; i++) begin
      btnU = (mpy + 32 > mby + 6);
      btnD = (mpy + 32 < mby + 2);
      doTick();
    end

    // keep the paddle away from the ball so that it is missed
    for (int i = 0; i < 400; i++) begin
      btnD = (mby + 4 < 240);
      btnU = !(mby + 4 < 240);
      doTick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    jumpTo((mbx > 6) ? mbx - 6 : 0, mby + 3); waitCycles(60);

    // pause freezes the game while the raster keeps running
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) doTick();
    jumpTo(630, 100); waitCycles(40);
    jumpTo(640, 10);  waitCycles(400);
    applyStimulus(1'b0, 1'b0, 1'b0);
    doTick();
    waitCycles(4);

    $display("[TB] paddle hits %0d, misses %0d", hits, misses);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/pong_vga_top.md
Name: pong_vga_top

Overview:
Single-player Pong top level: a paddle on the left edge, controlled by up/down buttons, and a bouncing ball, rendered on a 640x480 VGA display with 1-bit-per-colour RGB. It contains the VGA timing generator, the game-state update logic and the pixel renderer. On-board flash/RAM chip selects are held inactive so they do not drive shared buses.

Parameters:
PADDLE_H, 64, paddle height in pixels
PADDLE_STEP, 4, paddle move per frame in pixels
BALL_SIZE, 8, ball edge length in pixels
BALL_SPEED, 2, ball |dx| and |dy| per frame in pixels

Ports:
ClkPort  in  1  system clock (2x pixel rate, nominally 50 MHz)
Sw0  in  1  reset, synchronous, active-high
Sw1  in  1  pause; 1 = game state frozen, video still runs
btnU  in  1  paddle up (level, held)
btnD  in  1  paddle down (level, held)
St_ce_bar, St_rp_bar, Mt_ce_bar, Mt_St_oe_bar, Mt_St_we_bar  out  1 each  memory controls, constant 1
vga_h_sync  out  1  horizontal sync, active-low
vga_v_sync  out  1  vertical sync, active-low
vga_r, vga_g, vga_b  out  1 each  pixel colour

Behaviour:
- One clock domain (ClkPort). Sw0 is synchronous and active-high; no other reset exists.
- Pixel enable pe toggles every ClkPort cycle (pixel = ClkPort/2). pe = 0 in reset.
- hcnt counts 0..799 and wraps to 0, advancing on pe. vcnt counts 0..524 and advances when hcnt wraps.
- vga_h_sync = 0 when hcnt is 656..751. vga_v_sync = 0 when vcnt is 490..491.
- Visible area: hcnt<640 && vcnt<480. Outside it, RGB = 000.
- All outputs are registered (one-pixel pipeline). In reset: hcnt=vcnt=0, syncs=1, RGB=000.
- Frame tick: a one-ClkPort pulse on the pe cycle where hcnt=0 and vcnt=480. All game updates happen only on the frame tick, and only when Sw1=0.
- Paddle: fixed x 16..23. Reset y=208 (top edge); valid range 0..480-PADDLE_H (=416).
  - btnU alone: y -= PADDLE_STEP, clamped at 0.
  - btnD alone: y += PADDLE_STEP, clamped at 416.
  - Both buttons or neither: no move.
- Ball: top-left (bx,by). Reset bx=316, by=236, dx=+BALL_SPEED, dy=+BALL_SPEED. Each tick the next position is computed as b+d.
  - Top: if next by<=0, set by=0 and dy=+.
  - Bottom: if next by>=472, set by=472 and dy=-.
  - Right: if next bx>=632, set bx=632 and dx=-.
  - Paddle hit: dx<0, next bx<=24, and the ball's vertical span overlaps paddle y..y+63. Set bx=24 and dx=+.
  - Miss: dx<0, next bx<=0, no overlap. Ball returns to its reset position and velocity; paddle is unchanged.
  - Corner cases apply x and y rules independently in the same tick.
- Rendering priority, visible pixels only:
  - ball = red (100)
  - paddle = green (010)
  - border (optional) = blue (001)
  - otherwise black
- Reset mid-frame: counters restart at 0 on the next clock and game state is reinitialised.

Optional Feature:
PONG_BORDER_EN:
- When defined: an 8-pixel blue border is drawn on the top (vcnt 0..7), bottom (472..479) and right (hcnt 632..639) edges.
- When undefined: no border pixels are drawn (background black).
- Collision limits are identical in both cases.

Test Plan:
- Sw0=1 for 2 clocks, then 0 -> hcnt=vcnt=0, syncs=1, RGB=000. First hsync low at pixel 656, lasting 96 pixels. Line period = 1600 ClkPort cycles; frame period = 840000 ClkPort cycles.
- Idle after reset, first frame -> red pixels at x 316..323, y 236..243; green pixels at x 16..23, y 208..271. After 1 tick the ball is at (318,238).
- btnU held for 60 frames -> paddle y decreases by 4 per frame and holds at 0. btnD held -> paddle y holds at 416. Both held -> y unchanged.
- Ball driven toward bottom-right for 118 ticks -> ball reaches by=472, then dy becomes negative. At bx=632, dx becomes negative.
- Ball approaches left with paddle aligned -> bx clamped to 24 and dx becomes +2. Paddle moved away -> ball reappears at (316,236) moving +x,+y.
- Sw1=1 for 10 frames -> ball and paddle positions unchanged while syncs keep toggling. With PONG_BORDER_EN defined, pixel (639,100) is blue; undefined, it is black.
